sram_decode_stage: RTL
======================

# sram_decode_stage

Pipeline stage directly upstream of the 16-read/8-write decoded-address SRAM bank. It registers binary read/write indices, write data and write enables, and presents them one cycle later as one-hot decoded address rows. It also flags reads that collide with a write in the same stage and supplies the forwarded write data for them. Stall and flush controls let the surrounding pipeline hold or squash the stage.

## Interface
- SRAM_DEPTH, 64, number of entries; width of one decoded row
- SRAM_INDEX, 6, binary index width
- SRAM_WIDTH, 8, data width
- NUM_RD, 16, read ports
- NUM_WR, 8, write ports

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset
- stall_i  in  1  hold stage registers
- flush_i  in  1  squash captured contents
- rd_valid_i  in  NUM_RD  per-read-port valid
- rd_addr_i  in  NUM_RD*SRAM_INDEX  read indices; port k at [k*SRAM_INDEX +: SRAM_INDEX]
- we_i  in  NUM_WR  per-write-port enable
- wr_addr_i  in  NUM_WR*SRAM_INDEX  write indices
- wr_data_i  in  NUM_WR*SRAM_WIDTH  write data
- decoded_rd_o  out  NUM_RD*SRAM_DEPTH  one-hot read rows, feed SRAM read ports
- decoded_wr_o  out  NUM_WR*SRAM_DEPTH  one-hot write rows
- we_o  out  NUM_WR  registered write enables
- data_wr_o  out  NUM_WR*SRAM_WIDTH  registered write data
- rd_fwd_hit_o  out  NUM_RD  read index matches an enabled write in this stage
- rd_fwd_data_o  out  NUM_RD*SRAM_WIDTH  forwarded data for hitting reads, else 0
- wr_conflict_o  out  1  duplicate write index captured (macro only)
- conflict_cnt_o  out  8  saturating conflict count (macro only)

## Operation
- Capture: on each posedge with reset=1, flush_i=0, stall_i=0, all input buses load into the stage registers.
- Stall: stall_i=1 with flush_i=0 holds every register. Outputs stay unchanged.
- Flush: flush_i=1 clears the registered rd_valid and we to 0 and leaves addresses and data don't-care. Flush has priority over stall.
- Reset (reset=0 at posedge): clears all registers. Every output is then 0: decoded rows, we_o, data_wr_o, fwd outputs, wr_conflict_o and conflict_cnt_o. Reset has priority over flush and stall.
- Decode, combinational from registers:
  - decoded row bit j = 1 iff the port is valid/enabled and its index == j.
  - An index >= SRAM_DEPTH decodes to an all-zero row.
  - An invalid read port gives an all-zero row, so the SRAM returns 0.
- Forwarding:
  - rd_fwd_hit_o[k] = rd_valid[k] AND there exists write port w with we_o[w] and wr_addr[w]==rd_addr[k] and index < SRAM_DEPTH.
  - rd_fwd_data_o[k] = data of the highest-numbered matching w. This matches the SRAM's last-port-wins write ordering.
- Every decoded row output has at most one bit set.

## Timing
- Latency is 1 cycle from capture edge to decoded outputs.
- Forward outputs are combinational from stage registers, valid in the same cycle as decoded outputs.
- The SRAM writes at the edge that ends the stage cycle. A read in that cycle sees the old value, so consumers select rd_fwd_data_o when rd_fwd_hit_o=1.
- Back-to-back captures are supported with no bubbles.
- The deassertion of reset (first edge with reset=1) captures normally.

## Configuration
- SRAM_WR_CONFLICT_CHECK_EN defined:
  - When two or more enabled write ports in the stage share a valid index, we_o is forced to 0 for all but the highest-numbered of them.
  - wr_conflict_o=1 for every stage cycle holding such a set, including stalled cycles.
  - conflict_cnt_o increments by 1 at each capture edge that loads a conflicting set. It saturates at 255 and clears only on reset.
- Not defined:
  - we_o equals the registered we.
  - wr_conflict_o and conflict_cnt_o are tied to 0.
  - Forwarding is unchanged in either build.

## Test plan
- Reset: hold reset=0 two cycles with random inputs -> all outputs 0. Release with rd port 3 valid at index 5 -> the next cycle decoded_rd_o row 3 = 64'h20, other rows 0.
- Decode range: write port 0 at index 63 with data 8'hA5, plus read port 1 at index 64 (SRAM_INDEX=7 build) -> write row 0 bit 63 set, we_o[0]=1, data 8'hA5. Read row 1 = 0, fwd hit 0.
- Forwarding: write port 2 at index 9 with 8'h11 and port 6 at index 9 with 8'h66, read port 0 at index 9 -> rd_fwd_hit_o[0]=1, rd_fwd_data_o[0]=8'h66. With the macro: we_o[2]=0, wr_conflict_o=1, conflict_cnt_o=1.
- Stall/flush: capture a write at index 4, then stall_i=1 for 3 cycles -> outputs held. Then assert flush_i together with stall_i -> the next cycle we_o=0 and all rows 0.
- Saturation (macro): 300 consecutive conflicting captures -> conflict_cnt_o=255. Then reset=0 -> 0.

Source files
------------

// File: rtl/sram_decode_stage.sv
// -----------------------------------------------------------------------------
// sram_decode_stage
//
// Pipeline stage that sits directly in front of the decoded-address SRAM bank.
// It registers binary read/write indices, write data and write enables. One
// cycle later it presents them as one-hot address rows. Reads whose index
// matches an enabled write in the same stage are flagged, and the write data
// they need is forwarded. This is required because the SRAM returns the old
// contents during the cycle in which it is written.
//
// Optional feature macro: SRAM_WR_CONFLICT_CHECK_EN
//   When defined, a set of enabled write ports that share an in-range index
//   keeps only its highest-numbered port enabled. wr_conflict_o flags such a
//   set, and conflict_cnt_o counts the capture edges that loaded one
//   (saturating at 255). When undefined, we_o is the registered enable and both
//   conflict outputs are tied to zero.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : synchronous, active-low reset
//   stall_i        : hold every stage register
//   flush_i        : clear registered read valids and write enables
//                    (has priority over stall)
//   rd_valid_i     : per-read-port valid                 [NUM_RD]
//   rd_addr_i      : read indices, port k at [k*SRAM_INDEX +: SRAM_INDEX]
//   we_i           : per-write-port enable               [NUM_WR]
//   wr_addr_i      : write indices
//   wr_data_i      : write data, port w at [w*SRAM_WIDTH +: SRAM_WIDTH]
//   decoded_rd_o   : one-hot read rows,  row k at [k*SRAM_DEPTH +: SRAM_DEPTH]
//   decoded_wr_o   : one-hot write rows, row w at [w*SRAM_DEPTH +: SRAM_DEPTH]
//   we_o           : registered (possibly de-duplicated) write enables
//   data_wr_o      : registered write data
//   rd_fwd_hit_o   : read index matches an enabled write in this stage
//   rd_fwd_data_o  : forwarded data for hitting reads, zero otherwise
//   wr_conflict_o  : duplicate write index held in the stage
//   conflict_cnt_o : saturating count of conflicting captures
// -----------------------------------------------------------------------------
module sram_decode_stage #(
    parameter int SRAM_DEPTH = 64,
    parameter int SRAM_INDEX = 6,
    parameter int SRAM_WIDTH = 8,
    parameter int NUM_RD     = 16,
    parameter int NUM_WR     = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall_i,
    input  logic                           flush_i,
    input  logic [NUM_RD-1:0]              rd_valid_i,
    input  logic [NUM_RD*SRAM_INDEX-1:0]   rd_addr_i,
    input  logic [NUM_WR-1:0]              we_i,
    input  logic [NUM_WR*SRAM_INDEX-1:0]   wr_addr_i,
    input  logic [NUM_WR*SRAM_WIDTH-1:0]   wr_data_i,
    output logic [NUM_RD*SRAM_DEPTH-1:0]   decoded_rd_o,
    output logic [NUM_WR*SRAM_DEPTH-1:0]   decoded_wr_o,
    output logic [NUM_WR-1:0]              we_o,
    output logic [NUM_WR*SRAM_WIDTH-1:0]   data_wr_o,
    output logic [NUM_RD-1:0]              rd_fwd_hit_o,
    output logic [NUM_RD*SRAM_WIDTH-1:0]   rd_fwd_data_o,
    output logic                           wr_conflict_o,
    output logic [7:0]                     conflict_cnt_o
);

    // Stage registers
    logic [NUM_RD-1:0]            rd_valid_r;
    logic [NUM_RD*SRAM_INDEX-1:0] rd_addr_r;
    logic [NUM_WR-1:0]            we_r;
    logic [NUM_WR*SRAM_INDEX-1:0] wr_addr_r;
    logic [NUM_WR*SRAM_WIDTH-1:0] wr_data_r;

    // Write enables actually presented to the SRAM
    logic [NUM_WR-1:0]            we_eff_s;

    // True when an index addresses a real SRAM row
    function automatic logic idx_in_range(input logic [SRAM_INDEX-1:0] idx);
        return (32'(idx) < 32'(SRAM_DEPTH));
    endfunction

    // Capture, hold on stall, squash valids on flush, clear on reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid_r <= {NUM_RD{1'b0}};
            rd_addr_r  <= {(NUM_RD*SRAM_INDEX){1'b0}};
            we_r       <= {NUM_WR{1'b0}};
            wr_addr_r  <= {(NUM_WR*SRAM_INDEX){1'b0}};
            wr_data_r  <= {(NUM_WR*SRAM_WIDTH){1'b0}};
        end else if (flush_i) begin
            rd_valid_r <= {NUM_RD{1'b0}};
            we_r       <= {NUM_WR{1'b0}};
        end else if (!stall_i) begin
            rd_valid_r <= rd_valid_i;
            rd_addr_r  <= rd_addr_i;
            we_r       <= we_i;
            wr_addr_r  <= wr_addr_i;
            wr_data_r  <= wr_data_i;
        end else begin
            rd_valid_r <= rd_valid_r;
        end
    end

`ifdef SRAM_WR_CONFLICT_CHECK_EN
    // A port is shadowed when a higher-numbered enabled port writes the same
    // in-range index; the SRAM would let the higher port win anyway.
    function automatic logic [NUM_WR-1:0] shadowed_writes(
        input logic [NUM_WR-1:0]            we,
        input logic [NUM_WR*SRAM_INDEX-1:0] addr
    );
        logic [NUM_WR-1:0] mask;
        mask = {NUM_WR{1'b0}};
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                mask[a] = mask[a] | (we[a] & we[b]
                        & (addr[a*SRAM_INDEX +: SRAM_INDEX] == addr[b*SRAM_INDEX +: SRAM_INDEX])
                        & idx_in_range(addr[a*SRAM_INDEX +: SRAM_INDEX]));
            end
        end
        return mask;
    endfunction

    logic [NUM_WR-1:0] stage_dup_s;
    logic              in_conflict_s;
    logic [7:0]        conflict_cnt_r;

    assign stage_dup_s    = shadowed_writes(we_r, wr_addr_r);
    assign in_conflict_s  = |shadowed_writes(we_i, wr_addr_i);
    assign we_eff_s       = we_r & ~stage_dup_s;
    assign wr_conflict_o  = |stage_dup_s;
    assign conflict_cnt_o = conflict_cnt_r;

    // Count capture edges that load a conflicting write set, saturating
    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_cnt_r <= 8'h00;
        end else if (!flush_i && !stall_i && in_conflict_s && (conflict_cnt_r != 8'hFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 8'h01;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end
`else
    assign we_eff_s       = we_r;
    assign wr_conflict_o  = 1'b0;
    assign conflict_cnt_o = 8'h00;
`endif

    assign we_o      = we_eff_s;
    assign data_wr_o = wr_data_r;

    // One-hot row decode; out-of-range indices never match any row
    always_comb begin
        decoded_rd_o = {(NUM_RD*SRAM_DEPTH){1'b0}};
        decoded_wr_o = {(NUM_WR*SRAM_DEPTH){1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            for (int j = 0; j < SRAM_DEPTH; j++) begin
                decoded_rd_o[k*SRAM_DEPTH + j] = rd_valid_r[k]
                    & (32'(rd_addr_r[k*SRAM_INDEX +: SRAM_INDEX]) == 32'(j));
            end
        end
        for (int w = 0; w < NUM_WR; w++) begin
            for (int j = 0; j < SRAM_DEPTH; j++) begin
                decoded_wr_o[w*SRAM_DEPTH + j] = we_eff_s[w]
                    & (32'(wr_addr_r[w*SRAM_INDEX +: SRAM_INDEX]) == 32'(j));
            end
        end
    end

    // Forwarding: scan writes low to high so the highest-numbered match wins,
    // mirroring the SRAM's last-port-wins write ordering
    always_comb begin
        logic match_s;
        match_s       = 1'b0;
        rd_fwd_hit_o  = {NUM_RD{1'b0}};
        rd_fwd_data_o = {(NUM_RD*SRAM_WIDTH){1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                match_s = rd_valid_r[k] & we_eff_s[w]
                        & (wr_addr_r[w*SRAM_INDEX +: SRAM_INDEX] == rd_addr_r[k*SRAM_INDEX +: SRAM_INDEX])
                        & idx_in_range(wr_addr_r[w*SRAM_INDEX +: SRAM_INDEX]);
                rd_fwd_hit_o[k] = rd_fwd_hit_o[k] | match_s;
                rd_fwd_data_o[k*SRAM_WIDTH +: SRAM_WIDTH] = match_s
                        ? wr_data_r[w*SRAM_WIDTH +: SRAM_WIDTH]
                        : rd_fwd_data_o[k*SRAM_WIDTH +: SRAM_WIDTH];
            end
        end
    end

endmodule
